elixirchip_es1_spu_match_arbiter: RTL and testbench

//  Shares one elixirchip_es1_spu_op_match unit among NUM_REQ requesters.

---
 rtl/elixirchip_es1_spu_match_arbiter_pkg.sv | 40 ++++
 rtl/elixirchip_es1_spu_match_tag_pipe.sv | 36 +++
 rtl/elixirchip_es1_spu_match_arbiter.sv | 120 ++++++++++++
 tb/tb_elixirchip_es1_spu_match_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_match_arbiter_pkg.sv
// Shared types and helpers for the SPU match arbiter.
// Tags are sized for the largest supported requester count.
package elixirchip_es1_spu_match_arbiter_pkg;

  localparam int MAX_REQ  = 16;
  localparam int IDX_BITS = $clog2(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [IDX_BITS-1:0] idx;
  } tag_t;

  typedef struct packed {
    logic                found;
    logic [IDX_BITS-1:0] idx;
  } pick_t;

  // Scan downward so the requester nearest to ptr wins.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [IDX_BITS-1:0] ptr,
    input int                  n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (valid[j]) begin
          p.found = 1'b1;
          p.idx   = IDX_BITS'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_match_tag_pipe.sv
// Tag delay line that tracks ops through the shared match unit.
// Stalls with cke; flush invalidates every stage.
module elixirchip_es1_spu_match_tag_pipe
  import elixirchip_es1_spu_match_arbiter_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cke_i,
  input  logic flush_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [LATENCY];
  tag_t stage_d [LATENCY];

  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      stage_d[k] = (k == 0) ? tag_i : stage_q[(k == 0) ? 0 : k - 1];
      if (flush_i) stage_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= '0;
    end else if (cke_i) begin
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign tag_o = stage_q[LATENCY-1];

endmodule

// File: rtl/elixirchip_es1_spu_match_arbiter.sv
// Round-robin front end for one shared match unit.
// Issues one tagged op per cycle and steers results back.
module elixirchip_es1_spu_match_arbiter
  import elixirchip_es1_spu_match_arbiter_pkg::*;
#(
  parameter int    NUM_REQ    = 4,
  parameter int    DATA_BITS  = 8,
  parameter int    LATENCY    = 1,
  parameter logic  CLEAR_DATA = 1'b0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cke,
  input  logic [NUM_REQ*DATA_BITS-1:0]   s_req_data0,
  input  logic [NUM_REQ*DATA_BITS-1:0]   s_req_data1,
  input  logic [NUM_REQ-1:0]             s_req_valid,
  output logic [NUM_REQ-1:0]             s_req_ready,
  input  logic                           s_flush,
  output logic [DATA_BITS-1:0]           op_data0,
  output logic [DATA_BITS-1:0]           op_data1,
  output logic                           op_clear,
  output logic                           op_valid,
  input  logic                           op_result,
  output logic [NUM_REQ-1:0]             m_res_match,
  output logic [NUM_REQ-1:0]             m_res_valid
);

  logic [IDX_BITS-1:0]  rr_q, rr_d;
  logic [DATA_BITS-1:0] d0_q, d0_d, d1_q, d1_d;
  logic                 clr_q, clr_d, vld_q, vld_d;
  logic [NUM_REQ-1:0]   rv_q, rv_d, rm_q, rm_d;
  tag_t                 tag_q, tag_d, tag_out;
  pick_t                pick;
  logic                 grant;
  logic                 unused_cfg;

  assign unused_cfg = ^{CLEAR_DATA, DEVICE != "", DEBUG != ""};

  assign pick  = rr_pick(MAX_REQ'(s_req_valid), rr_q, NUM_REQ);
  assign grant = reset_n & cke & ~s_flush & pick.found;

  assign s_req_ready = grant ? (NUM_REQ'(1) << pick.idx) : '0;

  always_comb begin
    rr_d  = rr_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    clr_d = s_flush;
    vld_d = grant;
    tag_d = '0;
    if (grant) begin
      rr_d = (pick.idx == IDX_BITS'(NUM_REQ - 1)) ? '0 : pick.idx + 1'b1;
      d0_d = s_req_data0[int'(pick.idx)*DATA_BITS +: DATA_BITS];
      d1_d = s_req_data1[int'(pick.idx)*DATA_BITS +: DATA_BITS];
      tag_d.valid = 1'b1;
      tag_d.idx   = pick.idx;
    end
  end

  // A flush also kills the result leaving the pipe on that edge.
  always_comb begin
    rv_d = '0;
    rm_d = '0;
    if (tag_out.valid && !s_flush) begin
      rv_d = NUM_REQ'(1) << tag_out.idx;
      rm_d = op_result ? rv_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q  <= '0;
      d0_q  <= '0;
      d1_q  <= '0;
      clr_q <= 1'b0;
      vld_q <= 1'b0;
      tag_q <= '0;
      rv_q  <= '0;
      rm_q  <= '0;
    end else if (cke) begin
      rr_q  <= rr_d;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      clr_q <= clr_d;
      vld_q <= vld_d;
      tag_q <= tag_d;
      rv_q  <= rv_d;
      rm_q  <= rm_d;
    end
  end

  elixirchip_es1_spu_match_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .cke_i   (cke),
    .flush_i (s_flush),
    .tag_i   (tag_q),
    .tag_o   (tag_out)
  );

  assign op_data0    = d0_q;
  assign op_data1    = d1_q;
  assign op_clear    = clr_q;
  assign op_valid    = vld_q;
  assign m_res_valid = rv_q;
  assign m_res_match = rm_q;

  if (SIMULATION == "true") begin : g_sva
    always_ff @(posedge clk) begin
      assert ($onehot0(s_req_ready));
      assert ($onehot0(m_res_valid));
    end
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_match_arbiter.sv
// Randomized bench for the match arbiter with a queue-based
// reference model and a behavioural match unit.
module tb_elixirchip_es1_spu_match_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           cke;
  logic           s_flush;
  logic [N*W-1:0] d0, d1;
  logic [N-1:0]   vld, rdy;
  logic [W-1:0]   op_d0, op_d1;
  logic           op_clear, op_valid, op_result;
  logic [N-1:0]   res_m, res_v;

  always #5 clk = ~clk;

  elixirchip_es1_spu_match_arbiter #(
    .NUM_REQ    (N),
    .DATA_BITS  (W),
    .LATENCY    (L),
    .CLEAR_DATA (1'b0),
    .DEVICE     ("RTL"),
    .SIMULATION ("true"),
    .DEBUG      ("false")
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cke         (cke),
    .s_req_data0 (d0),
    .s_req_data1 (d1),
    .s_req_valid (vld),
    .s_req_ready (rdy),
    .s_flush     (s_flush),
    .op_data0    (op_d0),
    .op_data1    (op_d1),
    .op_clear    (op_clear),
    .op_valid    (op_valid),
    .op_result   (op_result),
    .m_res_match (res_m),
    .m_res_valid (res_v)
  );

  // Behavioural match unit: L-stage compare pipe stalled by cke.
  logic mpipe [L];
  initial for (int k = 0; k < L; k++) mpipe[k] = 1'b0;
  always @(posedge clk) begin
    if (cke) begin
      mpipe[0] <= op_clear ? 1'b0 : (op_d0 == op_d1);
      for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign op_result = mpipe[L-1];

  typedef struct {
    int due;
    int idx;
    bit m;
  } ev_t;

  ev_t          q[$];
  int           rr, ecnt, checks, errors;
  logic [N-1:0] e_v, e_m;
  logic         e_clr, e_opv;
  logic [W-1:0] e_d0, e_d1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (vld[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic tick();
    int           g;
    logic [N-1:0] e_rdy;
    #1;
    g = pick();
    e_rdy = (reset_n && cke && !s_flush && g >= 0) ? N'(1) << g : '0;
    chk("ready", 32'(rdy), 32'(e_rdy));
    @(posedge clk);
    if (!reset_n) begin
      rr = 0; q.delete();
      e_v = '0; e_m = '0; e_clr = 0; e_opv = 0;
      e_d0 = '0; e_d1 = '0;
    end else if (cke) begin
      ecnt++;
      e_v = '0; e_m = '0;
      if (s_flush) q.delete();
      else begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].due == ecnt) begin
            e_v[q[i].idx] = 1'b1;
            e_m[q[i].idx] = q[i].m;
            q.delete(i);
          end
        end
      end
      e_clr = s_flush;
      e_opv = !s_flush && g >= 0;
      if (e_opv) begin
        e_d0 = d0[g*W +: W];
        e_d1 = d1[g*W +: W];
        q.push_back('{ecnt + L + 1, g, e_d0 == e_d1});
        rr = (g + 1) % N;
      end
    end
    #1;
    chk("res_valid", 32'(res_v), 32'(e_v));
    chk("res_match", 32'(res_m), 32'(e_m));
    chk("op_valid", 32'(op_valid), 32'(e_opv));
    chk("op_clear", 32'(op_clear), 32'(e_clr));
    chk("op_data0", 32'(op_d0), 32'(e_d0));
    chk("op_data1", 32'(op_d1), 32'(e_d1));
  endtask

  task automatic set_req(input int i, input bit eq);
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = eq ? a : W'($urandom);
    if (!eq && b == a) b = ~a;
    d0[i*W +: W] = a;
    d1[i*W +: W] = b;
  endtask

  initial begin
    checks = 0; errors = 0; rr = 0; ecnt = 0;
    e_v = '0; e_m = '0; e_clr = 0; e_opv = 0; e_d0 = '0; e_d1 = '0;
    reset_n = 0; cke = 1; s_flush = 0; vld = '0; d0 = '0; d1 = '0;
    repeat (2) tick();
    reset_n = 1;

    // all valid: strict rotation, even requesters match
    vld = 4'b1111;
    for (int i = 0; i < N; i++) set_req(i, (i % 2) == 0);
    repeat (12) tick();

    // single requester every cycle
    vld = 4'b0100;
    repeat (10) tick();

    // issue to 1 and 3, flush before results emerge
    vld = 4'b1010;
    repeat (2) tick();
    vld = '0; s_flush = 1;
    tick();
    s_flush = 0;
    repeat (6) tick();

    // cke toggling with traffic
    vld = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      cke = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
      tick();
    end
    cke = 1;

    // reset mid-stream with ops in flight
    repeat (3) tick();
    reset_n = 0;
    repeat (2) tick();
    reset_n = 1; vld = '0;
    repeat (6) tick();

    // rr_ptr=3 case: req3 unequal, req0 equal
    vld = 4'b1000; tick();
    vld = 4'b0100; tick();
    d0[0 +: W] = 8'h5A; d1[0 +: W] = 8'h5A;
    d0[3*W +: W] = 8'h00; d1[3*W +: W] = 8'hFF;
    vld = 4'b1001;
    repeat (8) tick();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      cke     = ($urandom_range(0, 99) < 85);
      s_flush = ($urandom_range(0, 19) == 0);
      vld     = N'($urandom) & (($urandom_range(0, 3) == 0) ? N'($urandom) : '1);
      for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 1) == 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
